// File: rtl/stepper_pkg.sv
// stepper_pkg
// Shared types and constants for the stepper coil sequencer:
//   state_t      - sequencer state encoding
//   PHASE_TABLE  - 8-entry half-step coil table, entry 0 in bits [3:0]
//   PERIOD_MIN   - shortest allowed step period in clocks
//   phase_of()   - coil pattern lookup by table index
package stepper_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int PERIOD_MIN = 2;

    // Coil bit3 = A ... bit0 = D. Entries listed from index 7 down to 0.
    localparam logic [31:0] PHASE_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    function automatic logic [3:0] phase_of(input logic [2:0] idx);
        return PHASE_TABLE[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/step_rate_timer.sv
// step_rate_timer
// Loadable down-counter that sets the step cadence.
//   clk, reset  - clock, synchronous active-high reset
//   load        - start/restart a period of load_val clocks
//   load_val    - period length in clocks (must be >= 1)
//   clear       - stop counting; expire stays low until the next load
//   expire      - high during the last clock of the period
// After a load at edge T, expire is high in the cycle ending at edge T+load_val,
// so a consumer registering on expire acts exactly load_val edges after T.
module step_rate_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clear,
    output logic         expire
);

    logic [W-1:0] count;
    logic         active;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            active <= 1'b0;
        end else if (clear) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= load_val - W'(1);
            active <= 1'b1;
        end else if (active && (count != '0)) begin
            count  <= count - W'(1);
        end
    end

    // Terminal-count compare; the owner reloads or clears on the same cycle.
    assign expire = active && (count == '0);

endmodule

// File: rtl/stepper_phase_gen.sv
// stepper_phase_gen
// Coil sequencer for one 4-wire unipolar stepper. Accepts a move command,
// steps the coil table at the programmed rate and tracks absolute position.
//   clk, reset           - clock, synchronous active-high reset
//   cmd_valid/cmd_ready  - move handshake (ready only while idle)
//   cmd_steps            - step count, 0 = immediate done
//   cmd_dir              - 1 = index increments, 0 = decrements
//   cmd_half             - 1 = half-step (+-1), 0 = full-step (+-2)
//   cmd_period           - clocks per step, values below 2 run at 2
//   abort                - end the running move without taking another step
//   coil                 - registered coil drive, bit3 = A, bit0 = D
//   busy                 - move in progress
//   done                 - one-cycle pulse when a move ends
//   steps_left           - untaken steps of the current or last move
//   position             - signed step position, wraps
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a command; cmd_ready high
// ST_RUN  | stepping at the latched period until count reaches 0 or abort
module stepper_phase_gen
    import stepper_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int STEPS_W  = 16,
    parameter bit HOLD_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic                cmd_dir,
    input  logic                cmd_half,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic [3:0]          coil,
    output logic                busy,
    output logic                done,
    output logic [STEPS_W-1:0]  steps_left,
    output logic [STEPS_W-1:0]  position
);

    state_t              state, state_nxt;
    logic [2:0]          index, index_nxt, adv;
    logic                run_dir, run_half;
    logic [PERIOD_W-1:0] run_period, period_clamped, tmr_val;
    logic                tmr_load, tmr_clear, expire;
    logic                accept, step, done_nxt;
    logic [STEPS_W-1:0]  pos_nxt;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    assign period_clamped = (cmd_period < PERIOD_W'(PERIOD_MIN)) ?
                            PERIOD_W'(PERIOD_MIN) : cmd_period;

    assign adv       = run_half ? 3'd1 : 3'd2;
    assign index_nxt = run_dir ? (index + adv) : (index - adv);
    assign pos_nxt   = run_dir ? (position + STEPS_W'(1)) : (position - STEPS_W'(1));

    step_rate_timer #(
        .W (PERIOD_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .clear    (tmr_clear),
        .expire   (expire)
    );

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        tmr_val   = run_period;
        step      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_steps != '0) begin
                        state_nxt = ST_RUN;
                        tmr_load  = 1'b1;
                        tmr_val   = period_clamped;
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Abort takes priority over a coincident expiry.
                if (abort) begin
                    state_nxt = ST_IDLE;
                    tmr_clear = 1'b1;
                    done_nxt  = 1'b1;
                end else if (expire) begin
                    step = 1'b1;
                    if (steps_left == STEPS_W'(1)) begin
                        state_nxt = ST_IDLE;
                        tmr_clear = 1'b1;
                        done_nxt  = 1'b1;
                    end else begin
                        tmr_load  = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            index      <= '0;
            coil       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_left <= '0;
            position   <= '0;
            run_dir    <= 1'b0;
            run_half   <= 1'b0;
            run_period <= PERIOD_W'(PERIOD_MIN);
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            busy  <= (state_nxt == ST_RUN);

            if (accept) begin
                run_dir    <= cmd_dir;
                run_half   <= cmd_half;
                run_period <= period_clamped;
                steps_left <= cmd_steps;
            end

            if (step) begin
                index      <= index_nxt;
                steps_left <= steps_left - STEPS_W'(1);
                position   <= pos_nxt;
            end

            // Without hold, coils are de-energised on the edge that enters idle;
            // the index is kept so the next move continues the sequence.
            if (!HOLD_EN && (state_nxt == ST_IDLE)) begin
                coil <= 4'b0000;
            end else if (step) begin
                coil <= phase_of(index_nxt);
            end
        end
    end

endmodule

// File: tb/tb_stepper_phase_gen.sv
// tb_stepper_phase_gen
// Self-checking bench: a holding instance and a non-holding instance share
// all inputs. Each command pushes its expected coil/position/cycle per step
// and its expected done cycle into queues; a negedge monitor pops them as
// the DUT changes coil or pulses done. A vector table covers the main moves,
// hand-written sequences cover abort, held commands, reset and wrap.
module tb_stepper_phase_gen;

    localparam int PW = 24;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_dir = 1'b0;
    logic          cmd_half = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] cmd_steps = '0;
    logic [PW-1:0] cmd_period = '0;

    logic          ready_h, busy_h, done_h;
    logic [3:0]    coil_h;
    logic [SW-1:0] left_h, pos_h;
    logic          ready_n, busy_n, done_n;
    logic [3:0]    coil_n;
    logic [SW-1:0] left_n, pos_n;

    stepper_phase_gen #(.PERIOD_W(PW), .STEPS_W(SW), .HOLD_EN(1'b1)) u_hold (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_h),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half),
        .cmd_period(cmd_period), .abort(abort), .coil(coil_h), .busy(busy_h),
        .done(done_h), .steps_left(left_h), .position(pos_h)
    );

    stepper_phase_gen #(.PERIOD_W(PW), .STEPS_W(SW), .HOLD_EN(1'b0)) u_nohold (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_n),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half),
        .cmd_period(cmd_period), .abort(abort), .coil(coil_n), .busy(busy_n),
        .done(done_n), .steps_left(left_n), .position(pos_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  coil;
        logic [15:0] pos;
        int          at;
        bit          last;
    } step_t;

    typedef struct {
        int          steps;
        bit          dir;
        bit          half;
        int          period;
        bit          exp_busy;
        logic [3:0]  exp_coil;
        logic [15:0] exp_pos;
    } vec_t;

    step_t       sq[$];
    int          dq[$];
    logic [3:0]  ref_phase [8];
    int          m_idx = 0;
    logic [15:0] m_pos = '0;
    bit          mon_en = 1'b0;
    logic [3:0]  coil_prev;
    vec_t        vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_move(input int c0, input int steps, input bit dir, input bit half,
                             input int period, input int n_take, input bit push_done);
        int    p;
        int    adv;
        step_t e;
        p   = (period < 2) ? 2 : period;
        adv = half ? 1 : 2;
        for (int k = 1; k <= n_take; k++) begin
            m_idx  = dir ? (m_idx + adv) % 8 : (m_idx + 8 - adv) % 8;
            m_pos  = dir ? m_pos + 16'd1 : m_pos - 16'd1;
            e.coil = ref_phase[m_idx];
            e.pos  = m_pos;
            e.at   = c0 + k * p;
            e.last = (k == steps);
            sq.push_back(e);
        end
        if (push_done) dq.push_back(c0 + steps * p);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int steps, input bit dir, input bit half, input int period,
                         input int n_take, input bit push_done, input bit with_abort,
                         output int c0);
        int guard;
        guard = 0;
        while (!ready_h && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_h) check("ready_wait", 32'(ready_h), 32'd1);
        cmd_valid  = 1'b1;
        cmd_steps  = 16'(steps);
        cmd_dir    = dir;
        cmd_half   = half;
        cmd_period = 24'(period);
        abort      = with_abort;
        c0 = cyc + 1;
        push_move(c0, steps, dir, half, period, n_take, push_done);
        @(negedge clk);
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sq.size() != 0 || dq.size() != 0 || busy_h) && guard < 80000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 80000) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d steps and %0d done pulses outstanding, busy %0b",
                     sq.size(), dq.size(), busy_h);
            sq.delete();
            dq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        step_t e;
        if (mon_en) begin
            if (coil_h !== coil_prev) begin
                if (sq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_step: coil %b at cycle %0d", coil_h, cyc);
                end else begin
                    e = sq.pop_front();
                    check("step_coil", 32'(coil_h), 32'(e.coil));
                    check("step_position", 32'(pos_h), 32'(e.pos));
                    check("step_cycle", cyc, e.at);
                    check("nohold_coil", 32'(coil_n), e.last ? 32'd0 : 32'(e.coil));
                end
            end
            if (done_h) begin
                if (dq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: at cycle %0d", cyc);
                end else begin
                    check("done_cycle", cyc, dq.pop_front());
                end
            end
        end
        coil_prev = coil_h;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, ca, cb;

        ref_phase[0] = 4'b1000; ref_phase[1] = 4'b1100;
        ref_phase[2] = 4'b0100; ref_phase[3] = 4'b0110;
        ref_phase[4] = 4'b0010; ref_phase[5] = 4'b0011;
        ref_phase[6] = 4'b0001; ref_phase[7] = 4'b1001;

        //          steps dir half per busy coil     position
        vecs[0] = '{4,    1,  1,   10, 1,   4'b0010, 16'd4};
        vecs[1] = '{4,    0,  1,   3,  1,   4'b1000, 16'd0};
        vecs[2] = '{3,    0,  0,   5,  1,   4'b0100, 16'hfffd};
        vecs[3] = '{2,    1,  1,   0,  1,   4'b0010, 16'hffff};
        vecs[4] = '{3,    1,  0,   1,  1,   4'b0100, 16'd2};
        vecs[5] = '{0,    1,  1,   7,  0,   4'b0100, 16'd2};
        vecs[6] = '{1,    1,  1,   4,  1,   4'b0110, 16'd3};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_coil", 32'(coil_h), 32'd0);
        check("rst_busy", 32'(busy_h), 32'd0);
        check("rst_done", 32'(done_h), 32'd0);
        check("rst_steps_left", 32'(left_h), 32'd0);
        check("rst_position", 32'(pos_h), 32'd0);
        check("rst_ready", 32'(ready_h), 32'd1);
        check("rst_nohold_coil", 32'(coil_n), 32'd0);
        mon_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].steps, vecs[i].dir, vecs[i].half, vecs[i].period,
                  vecs[i].steps, 1'b1, 1'b0, c0);
            check($sformatf("vec%0d_busy_start", i), 32'(busy_h), 32'(vecs[i].exp_busy));
            drain();
            check($sformatf("vec%0d_coil", i), 32'(coil_h), 32'(vecs[i].exp_coil));
            check($sformatf("vec%0d_position", i), 32'(pos_h), 32'(vecs[i].exp_pos));
            check($sformatf("vec%0d_steps_left", i), 32'(left_h), 32'd0);
            check($sformatf("vec%0d_ready", i), 32'(ready_h), 32'd1);
            check($sformatf("vec%0d_nohold_idle", i), 32'(coil_n), 32'd0);
        end

        // Full-step from odd index: two coils on at a time.
        issue(2, 1'b1, 1'b0, 3, 2, 1'b1, 1'b0, c0);
        drain();
        check("odd_full_coil", 32'(coil_h), 32'b1001);
        check("odd_full_position", 32'(pos_h), 32'd5);

        // Abort coincident with the 3rd expiry: 2 steps taken.
        issue(10, 1'b1, 1'b1, 8, 2, 1'b0, 1'b0, c0);
        dq.push_back(c0 + 24);
        while (cyc != c0 + 23) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_steps_left", 32'(left_h), 32'd8);
        check("abort_busy", 32'(busy_h), 32'd0);
        check("abort_ready", 32'(ready_h), 32'd1);
        check("abort_coil", 32'(coil_h), 32'b1100);
        repeat (20) @(negedge clk);
        check("abort_steps_left_later", 32'(left_h), 32'd8);
        check("abort_position", 32'(pos_h), 32'd7);
        check("abort_queue_empty", 32'(sq.size() + dq.size()), 32'd0);

        // Abort while idle with a command offered: command accepted.
        issue(1, 1'b1, 1'b1, 2, 1, 1'b1, 1'b1, c0);
        check("idle_abort_busy", 32'(busy_h), 32'd1);
        drain();
        check("idle_abort_position", 32'(pos_h), 32'd8);

        // Command held during a move starts the cycle after done.
        issue(3, 1'b0, 1'b1, 4, 3, 1'b1, 1'b0, ca);
        cmd_valid  = 1'b1;
        cmd_steps  = 16'd2;
        cmd_dir    = 1'b1;
        cmd_half   = 1'b0;
        cmd_period = 24'd3;
        cb = ca + 13;
        push_move(cb, 2, 1'b1, 1'b0, 3, 2, 1'b1);
        check("held_ready_low", 32'(ready_h), 32'd0);
        while (cyc != ca + 12) @(negedge clk);
        check("held_ready_at_end", 32'(ready_h), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_second_busy", 32'(busy_h), 32'd1);
        drain();
        check("held_position", 32'(pos_h), 32'd7);
        check("held_coil", 32'(coil_h), 32'b0110);

        // Reset in the middle of a move.
        issue(5, 1'b1, 1'b1, 6, 1, 1'b0, 1'b0, c0);
        while (cyc != c0 + 8) @(negedge clk);
        check("pre_reset_busy", 32'(busy_h), 32'd1);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_coil", 32'(coil_h), 32'd0);
        check("midrst_nohold_coil", 32'(coil_n), 32'd0);
        check("midrst_busy", 32'(busy_h), 32'd0);
        check("midrst_done", 32'(done_h), 32'd0);
        check("midrst_steps_left", 32'(left_h), 32'd0);
        check("midrst_position", 32'(pos_h), 32'd0);
        check("midrst_ready", 32'(ready_h), 32'd1);
        check("midrst_queue_empty", 32'(sq.size() + dq.size()), 32'd0);
        m_idx = 0;
        m_pos = '0;
        @(negedge clk);
        check("midrst_done_after", 32'(done_h), 32'd0);
        mon_en = 1'b1;
        @(negedge clk);

        // Walk to the positive bound, then wrap.
        issue(32767, 1'b1, 1'b1, 2, 32767, 1'b1, 1'b0, c0);
        drain();
        check("wrap_max_position", 32'(pos_h), 32'h7fff);
        issue(1, 1'b1, 1'b1, 2, 1, 1'b1, 1'b0, c0);
        drain();
        check("wrap_min_position", 32'(pos_h), 32'h8000);
        check("wrap_coil", 32'(coil_h), 32'b1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
